fifo_asn: RTL and testbench

FIFO_ASN -- requirements
Module: fifo_asn

---
 rtl/fifo_asn.sv | 74 +++++++
 tb/tb_fifo_asn.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fifo_asn.sv
// fifo_asn: single-clock FIFO with registered read data and an occupancy count.
// FIFO_full/FIFO_empty are decoded from the count, so they reflect the post-edge state.
module fifo_asn #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk_w,
    input  logic             reset,
    input  logic [width-1:0] data_in,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [width-1:0] data_out,
    output logic             FIFO_full,
    output logic             FIFO_empty
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [width-1:0] data_out_q, data_out_d;
    logic             rd_accept, wr_accept;

    // A write while full is still accepted when a read frees a slot on the same edge;
    // a read while empty is never accepted, so stale memory is never exposed.
    always_comb begin
        rd_accept  = rd_en && (count_q != '0);
        wr_accept  = wr_en && ((count_q != FULL_CNT) || rd_accept);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_accept) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_accept) begin
            rptr_d     = rptr_q + AW'(1);
            data_out_d = mem_q[rptr_q];
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_w or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk_w) begin
        if (wr_accept) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    assign data_out   = data_out_q;
    assign FIFO_full  = (count_q == FULL_CNT);
    assign FIFO_empty = (count_q == '0);

endmodule

// File: tb/tb_fifo_asn.sv
// tb_fifo_asn: scoreboard bench for fifo_asn; a queue-based reference model predicts
// data_out and the flags for every edge, and a separate monitor compares them.
module tb_fifo_asn;
    localparam int W = 16;
    localparam int D = 8;

    typedef struct {
        logic [W-1:0] dout;
        logic         full;
        logic         empty;
    } exp_t;

    logic         clk_w;
    logic         reset;
    logic [W-1:0] data_in;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         FIFO_full;
    logic         FIFO_empty;

    int checks = 0;
    int passes = 0;

    exp_t         expQ[$];
    logic [W-1:0] modelQ[$];
    logic [W-1:0] modelDout;

    fifo_asn #(.width(W), .depth(D)) dut (
        .clk_w     (clk_w),
        .reset     (reset),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .FIFO_full (FIFO_full),
        .FIFO_empty(FIFO_empty)
    );

    initial clk_w = 1'b0;
    always #5 clk_w = ~clk_w;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one edge's inputs and predict the outcome from plain FIFO rules.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [W-1:0] data);
        exp_t e;
        logic rdOk, wrOk;
        @(negedge clk_w);
        wr_en   = wr;
        rd_en   = rd;
        data_in = data;
        rdOk = rd && (modelQ.size() > 0);
        wrOk = wr && ((modelQ.size() < D) || rdOk);
        if (rdOk) modelDout = modelQ.pop_front();
        if (wrOk) modelQ.push_back(data);
        e.dout  = modelDout;
        e.full  = (modelQ.size() == D);
        e.empty = (modelQ.size() == 0);
        expQ.push_back(e);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dout"},  32'(data_out),   32'h0);
        checkOutput({tag, "_empty"}, 32'(FIFO_empty), 32'h1);
        checkOutput({tag, "_full"},  32'(FIFO_full),  32'h0);
    endtask

    // Monitor: compares the DUT against the prediction queued for each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_w);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("data_out", 32'(data_out), 32'(e.dout));
                checkOutput("full",     32'(FIFO_full), 32'(e.full));
                checkOutput("empty",    32'(FIFO_empty), 32'(e.empty));
                checkOutput("flags_exclusive", 32'(FIFO_full & FIFO_empty), 32'h0);
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        modelDout = '0;
        reset   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = W'($urandom);
        // Reset held for 30 ns with arbitrary inputs toggling.
        for (int i = 0; i < 3; i++) begin
            #7;
            checkResetState("in_reset");
            data_in = W'($urandom);
            wr_en   = 1'($urandom);
            rd_en   = 1'($urandom);
            #3;
        end
        @(negedge clk_w);
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        checkResetState("after_reset");

        // Reads on empty are ignored.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, W'(i));
        // Fill, then one overflow attempt.
        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b0, W'(i));
        // Drain plus two extra reads on empty.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, W'(16'hdead));
        // Simultaneous read/write from empty, then drain the last word.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, W'(16'h100 + i));
        applyStimulus(1'b0, 1'b1, '0);
        // Pointer wrap.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, W'(16'h200 + i));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, W'(16'h300 + i));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, '0);
        // Full with simultaneous read and write.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, W'(16'h400 + i));
        applyStimulus(1'b1, 1'b1, 16'h4ff);
        applyStimulus(1'b0, 1'b1, '0);

        // Reset mid-operation with three words stored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, W'(16'h500 + i));
        @(posedge clk_w);
        #2;
        reset = 1'b0;
        #1;
        checkResetState("mid_reset");
        reset = 1'b1;
        modelQ.delete();
        modelDout = '0;
        applyStimulus(1'b0, 1'b1, '0);

        // Randomized traffic, first write-heavy then read-heavy.
        for (int i = 0; i < 400; i++) begin
            int wrBias;
            wrBias = (i % 100 < 50) ? 75 : 30;
            applyStimulus($urandom_range(0, 99) < wrBias,
                          $urandom_range(0, 99) < (100 - wrBias),
                          W'($urandom));
        end

        @(posedge clk_w);
        #3;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
